// File: rtl/dft_mag_accum.sv
// Batched complex-magnitude combiner: alpha-max-plus-beta-min magnitude per sample,
// then saturating sum / running max / shifted mean over BATCH_N samples, 5-register pipeline.
module dft_mag_accum #(
  parameter int DATA_W    = 16,
  parameter int BATCH_N   = 3,
  parameter int AVG_SHIFT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode_in,
  input  logic              clear_in,
  input  logic [DATA_W-1:0] data_re_in,
  input  logic [DATA_W-1:0] data_im_in,
  input  logic              valid_in,
  output logic [DATA_W-2:0] data_out,
  output logic              valid_out,
  output logic              sat_out
);

  localparam int ACC_W = DATA_W + $clog2(BATCH_N);
  localparam int CNT_W = (BATCH_N > 1) ? $clog2(BATCH_N) : 1;
  localparam logic [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BATCH_N - 1);

  // Handshake: a sample is taken on any rising edge where valid_in is high and clear_in
  // is low; there is no back-pressure, so the block accepts one sample every cycle.

  // The most negative input has no positive twin; it maps to the largest positive value.
  function automatic logic [DATA_W-2:0] sat_abs(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] neg;
    neg = '0 - x;
    if (!x[DATA_W-1])
      return x[DATA_W-2:0];
    else if (x[DATA_W-2:0] == '0)
      return '1;
    else
      return neg[DATA_W-2:0];
  endfunction

  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_batch_mode;

  logic              r_s1_valid, r_s1_first, r_s1_last;
  logic [1:0]        r_s1_mode;
  logic [DATA_W-2:0] r_s1_abs_re, r_s1_abs_im;

  logic              r_s2_valid, r_s2_first, r_s2_last;
  logic [1:0]        r_s2_mode;
  logic [DATA_W-1:0] r_s2_mag;

  logic [ACC_W-1:0]  r_acc;
  logic              r_s3_done;
  logic [1:0]        r_s3_mode;

  logic              r_s4_valid;
  logic              r_s4_sat;
  logic [DATA_W-2:0] r_s4_data;

  logic [DATA_W-2:0] r_data_out;
  logic              r_valid_out;
  logic              r_sat_out;

  logic              w_accept;
  logic              w_first;
  logic [1:0]        w_mode;
  logic [DATA_W-2:0] w_mx, w_mn;
  logic [DATA_W-1:0] w_mag;
  logic [ACC_W-1:0]  w_mag_ext;
  logic [ACC_W-1:0]  w_sel;
  logic              w_sat;

  assign w_accept  = valid_in && !clear_in;
  assign w_first   = (r_cnt == '0);
  assign w_mode    = w_first ? mode_in : r_batch_mode;

  assign w_mx      = (r_s1_abs_re >= r_s1_abs_im) ? r_s1_abs_re : r_s1_abs_im;
  assign w_mn      = (r_s1_abs_re >= r_s1_abs_im) ? r_s1_abs_im : r_s1_abs_re;
  // Worst case is 1.375 * (2^(DATA_W-1)-1), which still fits DATA_W unsigned bits.
  assign w_mag     = {1'b0, w_mx} + DATA_W'(w_mn >> 2) + DATA_W'(w_mn >> 3);
  assign w_mag_ext = ACC_W'(r_s2_mag);

  always_comb begin
    w_sel = r_acc;
    if (r_s3_mode == 2'd2)
      w_sel = r_acc >> AVG_SHIFT;
  end
  assign w_sat = (w_sel > SAT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_batch_mode <= '0;
      r_s1_valid   <= 1'b0;
      r_s1_first   <= 1'b0;
      r_s1_last    <= 1'b0;
      r_s1_mode    <= '0;
      r_s1_abs_re  <= '0;
      r_s1_abs_im  <= '0;
      r_s2_valid   <= 1'b0;
      r_s2_first   <= 1'b0;
      r_s2_last    <= 1'b0;
      r_s2_mode    <= '0;
      r_s2_mag     <= '0;
      r_acc        <= '0;
      r_s3_done    <= 1'b0;
      r_s3_mode    <= '0;
      r_s4_valid   <= 1'b0;
      r_s4_sat     <= 1'b0;
      r_s4_data    <= '0;
      r_data_out   <= '0;
      r_valid_out  <= 1'b0;
      r_sat_out    <= 1'b0;
    end else begin
      // Stage 1: batch bookkeeping and component magnitudes
      r_s1_valid  <= w_accept;
      r_s1_first  <= w_first;
      r_s1_last   <= (r_cnt == CNT_LAST);
      r_s1_mode   <= w_mode;
      r_s1_abs_re <= sat_abs(data_re_in);
      r_s1_abs_im <= sat_abs(data_im_in);
      if (w_accept) begin
        r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
        if (w_first)
          r_batch_mode <= mode_in;
      end

      // Stage 2: approximate magnitude
      r_s2_valid <= r_s1_valid;
      r_s2_first <= r_s1_first;
      r_s2_last  <= r_s1_last;
      r_s2_mode  <= r_s1_mode;
      r_s2_mag   <= w_mag;

      // Stage 3: accumulate; the first sample of a batch loads instead of combining
      r_s3_done <= r_s2_valid && r_s2_last;
      if (r_s2_valid) begin
        r_s3_mode <= r_s2_mode;
        if (r_s2_first)
          r_acc <= w_mag_ext;
        else if (r_s2_mode == 2'd1)
          r_acc <= (w_mag_ext > r_acc) ? w_mag_ext : r_acc;
        else
          r_acc <= r_acc + w_mag_ext;
      end

      // Stage 4: mode select and saturation
      r_s4_valid <= r_s3_done;
      if (r_s3_done) begin
        r_s4_sat  <= w_sat;
        r_s4_data <= w_sat ? '1 : w_sel[DATA_W-2:0];
      end

      // Stage 5: output registers hold until the next result
      r_valid_out <= r_s4_valid;
      if (r_s4_valid) begin
        r_data_out <= r_s4_data;
        r_sat_out  <= r_s4_sat;
      end

      // Clear drops the partial batch and every in-flight result, but keeps the last output
      if (clear_in) begin
        r_cnt       <= '0;
        r_acc       <= '0;
        r_s1_valid  <= 1'b0;
        r_s2_valid  <= 1'b0;
        r_s3_done   <= 1'b0;
        r_s4_valid  <= 1'b0;
        r_valid_out <= 1'b0;
      end
    end
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign sat_out   = r_sat_out;

endmodule

// File: tb/tb_dft_mag_accum.sv
// Directed bench for dft_mag_accum: table of batches with hand-computed results,
// plus clear, in-flight clear and mid-batch reset sequences.
module tb_dft_mag_accum;

  localparam int DATA_W = 16;
  localparam int NV     = 13;
  localparam int EW     = 48;

  logic              clk;
  logic              rst;
  logic [1:0]        mode_in;
  logic              clear_in;
  logic [DATA_W-1:0] data_re_in;
  logic [DATA_W-1:0] data_im_in;
  logic              valid_in;
  logic [DATA_W-2:0] data_out;
  logic              valid_out;
  logic              sat_out;

  dft_mag_accum #(.DATA_W(DATA_W), .BATCH_N(3), .AVG_SHIFT(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode_in    (mode_in),
    .clear_in   (clear_in),
    .data_re_in (data_re_in),
    .data_im_in (data_im_in),
    .valid_in   (valid_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .sat_out    (sat_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0][1:0]        mode;
    logic [2:0][DATA_W-1:0] re;
    logic [2:0][DATA_W-1:0] im;
    int                     gap;
    logic [DATA_W-2:0]      exp_data;
    logic                   exp_sat;
  } vec_t;

  vec_t             vecs [NV];
  logic [EW-1:0]    exp_q [$];
  int               n_checks = 0;
  int               n_fail   = 0;
  int               cyc      = 0;
  int               last_acc = 0;
  bit               mon_rst;
  logic [DATA_W-2:0] last_data = '0;
  logic              last_sat  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic send(input logic [DATA_W-1:0] re, input logic [DATA_W-1:0] im, input logic [1:0] m);
    data_re_in = re;
    data_im_in = im;
    mode_in    = m;
    valid_in   = 1'b1;
    clear_in   = 1'b0;
    tick();
    last_acc   = cyc;
    valid_in   = 1'b0;
  endtask

  task automatic push_exp(input logic [DATA_W-2:0] d, input logic s);
    logic [31:0] due;
    due = 32'(last_acc + 4);
    exp_q.push_back({due, s, d});
  endtask

  task automatic set_vec(input int i, input logic [1:0] m0, input logic [1:0] m1, input logic [1:0] m2,
                         input int r0, input int i0, input int r1, input int i1, input int r2, input int i2,
                         input int gap, input int d, input logic s);
    vecs[i].mode[0] = m0; vecs[i].mode[1] = m1; vecs[i].mode[2] = m2;
    vecs[i].re[0] = 16'(r0); vecs[i].im[0] = 16'(i0);
    vecs[i].re[1] = 16'(r1); vecs[i].im[1] = 16'(i1);
    vecs[i].re[2] = 16'(r2); vecs[i].im[2] = 16'(i2);
    vecs[i].gap = gap;
    vecs[i].exp_data = 15'(d);
    vecs[i].exp_sat  = s;
  endtask

  // scoreboard: every strobe must match the head of exp_q, including its due cycle
  always @(posedge clk) begin
    logic [EW-1:0] e;
    mon_rst = rst;
    cyc++;
    #2;
    if (mon_rst) begin
      last_data = '0;
      last_sat  = 1'b0;
    end else if (valid_out) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: got data %0d sat %0d, expected no strobe (cycle %0d)",
                 data_out, sat_out, cyc);
      end else begin
        e = exp_q.pop_front();
        check("strobe_cycle", 32'(cyc), e[47:16]);
        check("data_out", 32'(data_out), 32'(e[14:0]));
        check("sat_out", 32'(sat_out), 32'(e[15]));
        last_data = e[14:0];
        last_sat  = e[15];
      end
    end else begin
      check("hold_data", 32'(data_out), 32'(last_data));
      check("hold_sat", 32'(sat_out), 32'(last_sat));
    end
  end

  initial begin
    rst = 1'b1; mode_in = '0; clear_in = 1'b0;
    data_re_in = '0; data_im_in = '0; valid_in = 1'b0;

    set_vec(0,  0,0,0,  100,-40, 100,-40, 100,-40,          109, 345,   1'b0);
    set_vec(1,  0,0,0,  -32768,-32768, -32768,-32768, -32768,-32768, 2, 32767, 1'b1);
    set_vec(2,  1,0,0,  100,0, 0,-300, 50,50,                1, 300,   1'b0);
    set_vec(3,  2,2,2,  100,-40, 100,-40, 100,-40,           3, 86,    1'b0);
    set_vec(4,  3,3,3,  3,4, 3,4, 3,4,                       0, 12,    1'b0);
    set_vec(5,  1,1,1,  -32768,0, 1,1, 0,0,                  0, 32767, 1'b0);
    set_vec(6,  2,2,2,  -32768,-32768, -32768,-32768, -32768,-32768, 0, 32767, 1'b1);
    set_vec(7,  2,1,1,  30000,0, 30000,0, 30000,0,           0, 22500, 1'b0);
    set_vec(8,  1,1,1,  -32768,-32768, 5,-7, 0,1,            1, 32767, 1'b1);
    set_vec(9,  0,0,0,  10000,10000, 10000,10000, 10000,10000, 0, 32767, 1'b1);
    set_vec(10, 0,0,0,  -1,0, 0,-1, 1,-1,                    0, 3,     1'b0);
    set_vec(11, 2,2,2,  100,-40, 100,-40, 100,-40,           0, 86,    1'b0);
    set_vec(12, 0,0,0,  3,4, 3,4, 3,4,                       0, 12,    1'b0);

    // reset state
    repeat (3) tick();
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_sat_out", 32'(sat_out), 32'd0);
    rst = 1'b0;
    idle(2);

    // table-driven batches; gap 0 runs back-to-back at full rate
    for (int i = 0; i < NV; i++) begin
      for (int s = 0; s < 3; s++) begin
        send(vecs[i].re[s], vecs[i].im[s], vecs[i].mode[s]);
        if (s == 2) push_exp(vecs[i].exp_data, vecs[i].exp_sat);
        idle(vecs[i].gap);
      end
    end
    idle(8);

    // clear with a simultaneous valid sample: partial batch and that sample are dropped
    send(16'd1000, 16'd0, 2'd0);
    send(16'd1000, 16'd0, 2'd0);
    data_re_in = 16'd3; data_im_in = 16'd4; valid_in = 1'b1; clear_in = 1'b1;
    tick();
    clear_in = 1'b0; valid_in = 1'b0;
    idle(2);
    send(16'd3, 16'd4, 2'd0);
    send(16'd3, 16'd4, 2'd0);
    send(16'd3, 16'd4, 2'd0);
    push_exp(15'd12, 1'b0);
    idle(8);

    // clear arriving after the batch has left the accumulate stage suppresses its result
    send(16'd1000, 16'd0, 2'd0);
    send(16'd1000, 16'd0, 2'd0);
    send(16'd1000, 16'd0, 2'd0);
    idle(2);
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    idle(8);
    check("clear_suppress_hold", 32'(data_out), 32'd12);

    // reset after one sample of a batch
    send(16'd1000, 16'd0, 2'd0);
    rst = 1'b1;
    tick();
    check("midrst_data_out", 32'(data_out), 32'd0);
    check("midrst_valid_out", 32'(valid_out), 32'd0);
    check("midrst_sat_out", 32'(sat_out), 32'd0);
    rst = 1'b0;
    idle(3);
    send(16'd100, -16'sd40, 2'd0);
    send(16'd100, -16'sd40, 2'd0);
    send(16'd100, -16'sd40, 2'd0);
    push_exp(15'd345, 1'b0);

    // bounded drain of outstanding results
    for (int k = 0; k < 40 && exp_q.size() > 0; k++) tick();
    idle(4);
    check("pending_results", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
